// File: rtl/mux41.sv
// mux41: registered select of A, B, A+B or A^B with a registered zero flag.
module mux41 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S1,
    input  logic             S0,
    output logic [WIDTH-1:0] Y,
    output logic             Z
);
    logic [WIDTH-1:0] nxt;
    always_comb nxt = S1 ? (S0 ? A ^ B : A + B) : (S0 ? B : A);
    always_ff @(posedge clk) begin
        if (rst) begin
            Y <= '0;
            Z <= 1'b1;
        end else begin
            Y <= nxt;
            Z <= nxt == '0;
        end
    end
endmodule

// File: tb/tb_mux41.sv
// tb_mux41: directed vectors with hand-computed results for mux41.
module tb_mux41;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        S1 = 1'b0;
    logic        S0 = 1'b0;
    logic [31:0] Y;
    logic        Z;
    int checks = 0;
    int errors = 0;

    mux41 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .S1(S1), .S0(S0), .Y(Y), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] ey, input logic ez);
        checks++;
        assert (Y === ey) else begin
            errors++;
            $error("FAIL %s Y got %h expected %h", tag, Y, ey);
        end
        checks++;
        assert (Z === ez) else begin
            errors++;
            $error("FAIL %s Z got %b expected %b", tag, Z, ez);
        end
    endtask

    // Drive inputs, let one rising edge load them, then check just after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] s, input logic [31:0] ey, input logic ez,
                        input string tag);
        rst = r;
        A = a;
        B = b;
        {S1, S0} = s;
        @(posedge clk);
        #1;
        check(tag, ey, ez);
    endtask

    initial begin
        step(1'b1, 32'h5, 32'h16, 2'b11, 32'h0, 1'b1, "reset_c1");
        step(1'b1, 32'h5, 32'h16, 2'b11, 32'h0, 1'b1, "reset_c2");
        step(1'b0, 32'h5, 32'h16, 2'b11, 32'h13, 1'b0, "xor_5_16");
        step(1'b0, 32'hA, 32'hF, 2'b01, 32'hF, 1'b0, "sel_b");
        step(1'b0, 32'hA, 32'hA, 2'b10, 32'h14, 1'b0, "add_a_a");
        step(1'b0, 32'h14, 32'h12, 2'b00, 32'h14, 1'b0, "sel_a");
        step(1'b0, 32'hFFFFFFFF, 32'h1, 2'b10, 32'h0, 1'b1, "add_wrap");
        step(1'b0, 32'h1234, 32'h1234, 2'b11, 32'h0, 1'b1, "xor_equal");
        step(1'b0, 32'h6, 32'h3, 2'b10, 32'h9, 1'b0, "add_6_3");
        step(1'b1, 32'h6, 32'h3, 2'b11, 32'h0, 1'b1, "reset_priority");
        step(1'b0, 32'h6, 32'h3, 2'b11, 32'h5, 1'b0, "after_release");
        #1 begin A = 32'h0; B = 32'h0; {S1, S0} = 2'b00; end
        #1 begin A = 32'hDEAD; B = 32'hBEEF; {S1, S0} = 2'b10; end
        #1 begin A = 32'h1; B = 32'h1; {S1, S0} = 2'b11; end
        check("glitch_hold", 32'h5, 1'b0);
        step(1'b0, 32'h80000000, 32'h80000000, 2'b10, 32'h0, 1'b1, "add_msb_carry");
        step(1'b0, 32'h0, 32'h7, 2'b00, 32'h0, 1'b1, "sel_a_zero");
        step(1'b0, 32'hF0F0F0F0, 32'h0F0F0F0F, 2'b11, 32'hFFFFFFFF, 1'b0, "xor_ones");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
